trace_commit_sink: RTL and testbench
====================================

// Module: trace_commit_sink
// PURPOSE
//  Consumer end of the instruction trace path. Takes the retired-instruction record at
//  writeback (instr_W_TR + PC) and buffers it in a small FIFO. Drains it to an external
//  trace port (difftest/UART bridge) over a valid/ready handshake.
//  Tags every record with a sequence number so the host can detect gaps.
//  Counts retirements and dropped records.
// PARAMETERS
//  DEPTH   8   FIFO entries; power of two, >=2
//  SEQ_W   16  sequence-number width; wraps modulo 2^SEQ_W
//  CNT_W   32  retire/drop counter width
// PORTS
//  clk         in   1      rising-edge clock; the block's only clock
//  rst         in   1      asynchronous, active-high reset
//  valid_W     in   1      writeback stage holds a valid instruction this cycle
//  pc_W        in   32     PC of the writeback instruction
//  instr_W     in   32     instruction word at writeback (instr_W_TR); 32'h0 = bubble
//  tr_ready    in   1      downstream accepts the head record
//  tr_valid    out  1      head record available
//  tr_seq      out  SEQ_W  sequence number of the head record
//  tr_pc       out  32     PC of the head record
//  tr_instr    out  32     instruction word of the head record
//  level       out  log2(DEPTH)+1  current FIFO occupancy
//  retire_cnt  out  CNT_W  total retirements seen; wraps
//  drop_cnt    out  CNT_W  records lost to a full FIFO; saturates at all-ones
//  overflow    out  1      sticky: at least one drop since reset or since clr_ovf
//  clr_ovf     in   1      synchronous clear of overflow and drop_cnt
// BEHAVIOUR
//  - Retire event: ret = valid_W && (instr_W != 0). A zero word is the flush/reset bubble.
//    A zero word is never counted and never enqueued.
//  - On ret:
//    * retire_cnt increments.
//    * seq_ctr increments, whether or not the record is enqueued.
//    * The record carries the pre-increment seq_ctr value.
//    * A lost record therefore appears as a seq gap at the host.
//  - Pop: pop = tr_valid && tr_ready. The head advances on the next clock edge.
//  - Push: push = ret && (!full || pop). Pushing into a full FIFO is legal when a pop
//    happens in the same cycle.
//  - Drop: drop = ret && full && !pop.
//    * drop_cnt increments, holding at all-ones.
//    * overflow is set.
//    * FIFO contents are unchanged.
//  - FIFO is first-word-fall-through:
//    * tr_valid = !empty.
//    * tr_seq/tr_pc/tr_instr show the head entry.
//    * Head fields are stable while tr_valid && !tr_ready.
//    * Latency from ret into an empty FIFO to tr_valid=1 is 1 cycle. No combinational
//      path from the valid_W inputs to the outputs.
//  - Push and pop in the same cycle: level is unchanged.
//  - Read and write pointers wrap modulo DEPTH. level ranges 0..DEPTH.
//    full = (level == DEPTH), empty = (level == 0).
//  - clr_ovf clears overflow and drop_cnt.
//    * A drop in the same cycle wins: overflow=1, drop_cnt=1.
//    * clr_ovf does not affect the FIFO, seq_ctr or retire_cnt.
//  - Reset (async; acts immediately, including mid-burst):
//    * Pointers and level go to 0, so tr_valid=0.
//    * seq_ctr, retire_cnt and drop_cnt go to 0; overflow goes to 0.
//    * Head data outputs read 0.
//    * Any record in flight is discarded.
//  - tr_ready while empty has no effect; there is no underflow.
// STRUCTURE
//  - Shared header trace_defs.vh holds:
//    * TR_REC_W = SEQ_W+64, the record width.
//    * Field offset localparams for {seq,pc,instr}.
//    * TR_BUBBLE = 32'h0.
//  - Sub-module trace_fifo #(WIDTH,DEPTH): synchronous FWFT FIFO with async reset.
//    * Storage: register array.
//    * Ports: push, pop, din, dout, full, empty, level.
//  - Top level holds the ret/push/drop logic, seq_ctr, the counters and overflow.
//    * It instantiates a single trace_fifo.
// TESTING
//  1 Reset, then 3 rets with tr_ready=1: PC 0x8000_0000/04/08, instr 0x0000_0013.
//    -> tr_valid 1 cycle after each ret; seq 0,1,2; retire_cnt=3; level never >1.
//  2 tr_ready=0, 10 consecutive rets (DEPTH=8).
//    -> level=8; drop_cnt=2; overflow=1; retire_cnt=10.
//    -> Then tr_ready=1 drains seq 0..7 in order; the next record pushed gets seq 10.
//  3 FIFO full, ret and pop in the same cycle.
//    -> no drop; level stays 8; the new record enters with the next seq.
//  4 valid_W=1 with instr_W=0 for 4 cycles.
//    -> no push; retire_cnt, seq_ctr and level unchanged.
//  5 rst asserted mid-drain at level 5, between clock edges.
//    -> tr_valid=0 and level=0 immediately.
//    -> After release, the first ret produces seq 0.
//  6 clr_ovf=1 in the same cycle as a drop.
//    -> overflow=1, drop_cnt=1. A later clr_ovf with no drop clears both to 0.

Source files
------------

// File: rtl/trace_commit_sink_pkg.sv
// Shared definitions for the instruction trace sink.
// A trace record is {seq, pc, instr}: instr in the low word, pc above it,
// seq on top. The body (pc + instr) has a fixed width; seq width is a
// parameter of the top, so the full record width is computed with tr_rec_w().
package trace_commit_sink_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned TR_BODY_W    = 2 * XLEN;

  // Field offsets inside a packed record
  localparam int unsigned TR_INSTR_LSB = 0;
  localparam int unsigned TR_PC_LSB    = XLEN;
  localparam int unsigned TR_SEQ_LSB   = TR_BODY_W;

  // Instruction word used for flush/reset bubbles; never a real retirement
  localparam logic [XLEN-1:0] TR_BUBBLE = '0;

  // Fixed part of a record; field order matches the offsets above
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } tr_body_t;

  // Full record width for a given sequence-number width
  function automatic int unsigned tr_rec_w(input int unsigned seq_w);
    return seq_w + TR_BODY_W;
  endfunction

endpackage

// File: rtl/trace_commit_sink_fifo.sv
// Synchronous first-word-fall-through FIFO, register-array storage.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, din       write request and data; ignored when full unless popping
//   pop             read request; ignored when empty
//   dout            head entry (valid when !empty)
//   full, empty     occupancy flags
//   level           current occupancy, 0..DEPTH
module trace_commit_sink_fifo #(
  parameter int unsigned WIDTH = 80,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  // Pointers rely on natural binary wrap, so DEPTH must be a power of two
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("trace_commit_sink_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             pop_ok;
  logic             push_ok;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts push
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage; cleared on reset so the head reads zero until the first push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/trace_commit_sink.sv
// Consumer end of the instruction trace path. Captures retired instructions
// at writeback, tags each with a sequence number, buffers them in a FWFT FIFO
// and drains them over a valid/ready trace port. Records that find the FIFO
// full are dropped and show up at the host as a gap in the sequence numbers.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   valid_W, pc_W, instr_W       writeback stage instruction (instr 0 = bubble)
//   tr_ready                     downstream accepts the head record
//   tr_valid, tr_seq, tr_pc,     head record of the trace FIFO
//   tr_instr
//   level                        FIFO occupancy
//   retire_cnt                   retirements seen (wraps)
//   drop_cnt                     records dropped (saturates)
//   overflow                     sticky drop flag
//   clr_ovf                      synchronous clear of overflow and drop_cnt
module trace_commit_sink
  import trace_commit_sink_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_W,
  input  logic [31:0]            pc_W,
  input  logic [31:0]            instr_W,
  input  logic                   tr_ready,
  output logic                   tr_valid,
  output logic [SEQ_W-1:0]       tr_seq,
  output logic [31:0]            tr_pc,
  output logic [31:0]            tr_instr,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int unsigned REC_W = tr_rec_w(SEQ_W);

  logic [SEQ_W-1:0] seq_ctr;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_head;
  tr_body_t         body_in;
  logic             ret;
  logic             pop;
  logic             push;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;

  // Retire / push / drop decode
  assign ret  = valid_W && (instr_W != TR_BUBBLE);
  assign pop  = tr_valid && tr_ready;
  assign push = ret && (!fifo_full || pop);
  assign drop = ret && fifo_full && !pop;

  // Record carries the sequence number before this retirement's increment
  assign body_in = '{pc: pc_W, instr: instr_W};
  assign rec_in  = {seq_ctr, body_in};

  trace_commit_sink_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (rec_in),
    .dout  (rec_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign tr_valid = !fifo_empty;
  assign tr_seq   = rec_head[TR_SEQ_LSB   +: SEQ_W];
  assign tr_pc    = rec_head[TR_PC_LSB    +: XLEN];
  assign tr_instr = rec_head[TR_INSTR_LSB +: XLEN];

  // Sequence number and retire count advance on every retirement, kept or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_ctr    <= '0;
      retire_cnt <= '0;
    end else if (ret) begin
      seq_ctr    <= seq_ctr + SEQ_W'(1);
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // Drop accounting; a drop in the same cycle as clr_ovf restarts the count at 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf) begin
        drop_cnt <= CNT_W'(1);
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end else if (clr_ovf) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trace_commit_sink.sv
module tb_trace_commit_sink;

  logic        clk;
  logic        rst;
  logic        valid_W;
  logic [31:0] pc_W;
  logic [31:0] instr_W;
  logic        tr_ready;
  logic        tr_valid;
  logic [15:0] tr_seq;
  logic [31:0] tr_pc;
  logic [31:0] tr_instr;
  logic [3:0]  level;
  logic [31:0] retire_cnt;
  logic [31:0] drop_cnt;
  logic        overflow;
  logic        clr_ovf;

  int n_checks = 0;
  int n_errors = 0;

  trace_commit_sink #(.DEPTH(8), .SEQ_W(16), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_W    (valid_W),
    .pc_W       (pc_W),
    .instr_W    (instr_W),
    .tr_ready   (tr_ready),
    .tr_valid   (tr_valid),
    .tr_seq     (tr_seq),
    .tr_pc      (tr_pc),
    .tr_instr   (tr_instr),
    .level      (level),
    .retire_cnt (retire_cnt),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_W = 1'b0; pc_W = '0; instr_W = '0; tr_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 64'(tr_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_retire", 64'(retire_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_seq", 64'(tr_seq), 64'd0);
    chk("rst_pc", 64'(tr_pc), 64'd0);
    chk("rst_instr", 64'(tr_instr), 64'd0);

    // Test 1: three rets streaming through with tr_ready=1
    tr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_W = 1'b1;
      pc_W    = 32'h8000_0000 + 32'(4 * i);
      instr_W = 32'h0000_0013;
      if (i == 0) begin
        #1;
        chk("t1_no_comb_path", 64'(tr_valid), 64'd0);
      end
      tick();
      chk("t1_valid", 64'(tr_valid), 64'd1);
      chk("t1_seq", 64'(tr_seq), 64'(i));
      chk("t1_pc", 64'(tr_pc), 64'(32'h8000_0000 + 32'(4 * i)));
      chk("t1_instr", 64'(tr_instr), 64'h13);
      chk("t1_level", 64'(level), 64'd1);
    end
    valid_W = 1'b0;
    tick();
    chk("t1_retire", 64'(retire_cnt), 64'd3);
    chk("t1_level_end", 64'(level), 64'd0);
    chk("t1_valid_end", 64'(tr_valid), 64'd0);

    // Test 2: ten rets into a stalled FIFO
    do_reset();
    tr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid_W = 1'b1;
      pc_W    = 32'h100 + 32'(4 * i);
      instr_W = 32'h0010_0093;
      tick();
    end
    valid_W = 1'b0;
    chk("t2_level", 64'(level), 64'd8);
    chk("t2_drop", 64'(drop_cnt), 64'd2);
    chk("t2_ovf", 64'(overflow), 64'd1);
    chk("t2_retire", 64'(retire_cnt), 64'd10);
    chk("t2_head_seq", 64'(tr_seq), 64'd0);
    chk("t2_head_pc", 64'(tr_pc), 64'h100);
    tick();
    chk("t2_head_stable", 64'(tr_seq), 64'd0);

    // Test 3: full FIFO, ret and pop in the same cycle
    valid_W  = 1'b1;
    pc_W     = 32'h200;
    instr_W  = 32'h0000_0013;
    tr_ready = 1'b1;
    tick();
    valid_W  = 1'b0;
    tr_ready = 1'b0;
    chk("t3_level", 64'(level), 64'd8);
    chk("t3_drop", 64'(drop_cnt), 64'd2);
    chk("t3_retire", 64'(retire_cnt), 64'd11);
    chk("t3_head_seq", 64'(tr_seq), 64'd1);
    chk("t3_head_pc", 64'(tr_pc), 64'h104);

    // Drain: seq 1..7, then the record pushed in test 3 with seq 10
    tr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", 64'(tr_valid), 64'd1);
      chk("drain_seq", 64'(tr_seq), (k < 7) ? 64'(k + 1) : 64'd10);
      chk("drain_pc", 64'(tr_pc), (k < 7) ? 64'(32'h100 + 32'(4 * (k + 1))) : 64'h200);
      tick();
    end
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_empty", 64'(tr_valid), 64'd0);

    // Test 4: bubbles are neither counted nor enqueued
    valid_W = 1'b1;
    pc_W    = 32'h300;
    instr_W = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_level", 64'(level), 64'd0);
      chk("t4_retire", 64'(retire_cnt), 64'd11);
    end
    pc_W     = 32'h304;
    instr_W  = 32'h0000_0013;
    tr_ready = 1'b0;
    tick();
    valid_W = 1'b0;
    chk("t4_seq_after", 64'(tr_seq), 64'd11);
    chk("t4_level_after", 64'(level), 64'd1);
    chk("t4_retire_after", 64'(retire_cnt), 64'd12);

    // Test 5: async reset mid-drain at level 5
    do_reset();
    tr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_W = 1'b1;
      pc_W    = 32'h400 + 32'(4 * i);
      instr_W = 32'h0000_0013;
      tick();
    end
    valid_W  = 1'b0;
    tr_ready = 1'b1;
    tick();
    chk("t5_level_pre", 64'(level), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid_rst", 64'(tr_valid), 64'd0);
    chk("t5_level_rst", 64'(level), 64'd0);
    chk("t5_pc_rst", 64'(tr_pc), 64'd0);
    chk("t5_retire_rst", 64'(retire_cnt), 64'd0);
    tick();
    rst      = 1'b0;
    tr_ready = 1'b0;
    valid_W  = 1'b1;
    pc_W     = 32'h500;
    instr_W  = 32'h0000_0013;
    tick();
    chk("t5_seq0", 64'(tr_seq), 64'd0);
    chk("t5_pc0", 64'(tr_pc), 64'h500);

    // Test 6: fill, drop twice, then clr_ovf together with a drop
    for (int i = 1; i < 10; i++) begin
      pc_W = 32'h500 + 32'(4 * i);
      tick();
    end
    chk("t6_level_full", 64'(level), 64'd8);
    chk("t6_drop_pre", 64'(drop_cnt), 64'd2);
    pc_W    = 32'h528;
    clr_ovf = 1'b1;
    tick();
    valid_W = 1'b0;
    chk("t6_ovf_clr_drop", 64'(overflow), 64'd1);
    chk("t6_drop_clr_drop", 64'(drop_cnt), 64'd1);
    chk("t6_retire", 64'(retire_cnt), 64'd11);
    tick();
    clr_ovf = 1'b0;
    chk("t6_ovf_clr", 64'(overflow), 64'd0);
    chk("t6_drop_clr", 64'(drop_cnt), 64'd0);
    chk("t6_level_kept", 64'(level), 64'd8);
    chk("t6_head_kept", 64'(tr_seq), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
